xor_parity_accum: RTL and testbench
===================================

// Module: xor_parity_accum
// PURPOSE
//   Streaming, parametrised XOR parity engine. Folds a frame of WIDTH-bit words into
//   per-bit (column) parity plus one overall parity bit, in even or odd mode.
//   Optionally checks the result against an expected parity bit.
//   Sits between a valid/ready producer and consumer; one result per frame.
// PARAMETERS
//   WIDTH      8   data word width in bits (>=1)
//   MAX_WORDS  16  max words per frame; the frame is force-closed at this count (>=1)
//   CW = $clog2(MAX_WORDS+1), derived localparam: word-counter width
// PORTS
//   clk           in   1      rising-edge clock
//   rst_n         in   1      asynchronous, active-low reset
//   in_valid      in   1      input word present
//   in_ready      out  1      block can accept a word
//   in_data       in   WIDTH  input word
//   in_last       in   1      word is last of frame
//   odd_sel       in   1      1 = odd parity, 0 = even; sampled with first word of frame
//   check_en      in   1      enable parity check; sampled with closing word
//   check_bit     in   1      expected parity; sampled with closing word
//   out_valid     out  1      result available
//   out_ready     in   1      consumer takes result
//   out_lane_par  out  WIDTH  XOR of all frame words, bitwise
//   out_parity    out  1      ^out_lane_par XOR latched odd_sel
//   out_count     out  CW     words in frame (1..MAX_WORDS)
//   out_err       out  1      check_en & (check_bit != out_parity)
//   out_ovf       out  1      frame force-closed at MAX_WORDS without in_last
// BEHAVIOUR
//   - Reset (async, rst_n=0): state=IDLE; accumulators, counter, all out_* = 0; in_ready=1.
//   - FSM states IDLE, ACCUM, HOLD; in_ready = (state != HOLD); out_valid = (state == HOLD).
//   - Accept = in_valid & in_ready.
//   - IDLE + accept: acc<=in_data, cnt<=1, odd latched <= odd_sel.
//     Goes to HOLD if closing, else ACCUM.
//   - ACCUM + accept: acc<=acc^in_data, cnt<=cnt+1; goes to HOLD if closing, else stays ACCUM.
//   - Closing word: in_last=1, OR the accepted word makes cnt==MAX_WORDS.
//     Forced close sets out_ovf=1 if in_last=0.
//     If in_last=1 on the MAX_WORDS-th word, out_ovf=0.
//   - On closing accept, all out_* are registered. out_valid rises the next cycle:
//     latency 1 clk from closing word to result.
//   - HOLD: out_* stable while out_ready=0, and in_ready=0, so no word is lost.
//     out_valid&out_ready -> IDLE next cycle.
//     Minimum frame period: 2 clk (one bubble per frame).
//   - out_* keep the last result after HOLD exits; only out_valid drops.
//   - No gaps required: in_valid may drop mid-frame; the accumulator holds.
//   - Unsigned counter, never wraps; the MAX_WORDS force-close prevents overflow.
//   - Asserting rst_n mid-frame or in HOLD discards the frame.
//     No output is produced for the discarded frame.
// TESTING (WIDTH=8, MAX_WORDS=4 unless noted)
//   1 Single word 8'hA5, last, even -> next clk: out_valid=1, lane=A5, parity=0,
//     count=1, err=0, ovf=0.
//   2 Words 01,02,04 (last on 04), odd_sel=1 -> lane=07, parity=0, count=3.
//     Also sweep all 8 three-bit patterns (WIDTH=1, 3-word frames), odd/even.
//   3 Backpressure: out_ready=0 for 5 clk after result -> out_* stable, in_ready=0.
//     Pending in_data=8'h11 is not taken until 1 clk after out_ready=1.
//   4 Overflow: FF,FF,FF,FF with in_last=0 -> lane=00, parity=0, count=4, ovf=1.
//     The next word starts a new frame.
//   5 Check: 8'h03 last, check_en=1, check_bit=1 -> parity=0, err=1.
//     Repeat with check_bit=0 -> err=0. With check_en=0 -> err=0.
//   6 Reset mid-frame after 2 words -> outputs 0 immediately, no result emitted.
//     Then 8'h80 last -> parity=1, count=1.

Source files
------------

// File: rtl/xor_parity_accum.sv
// xor_parity_accum
//   Streaming XOR parity engine. It folds each frame of WIDTH-bit words into a
//   per-column parity word and one overall parity bit, in even or odd mode. It
//   can also compare the result against an expected parity bit. The block
//   produces one registered result per frame, behind valid/ready handshakes.
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   in_valid/ready    input word handshake; in_data word, in_last marks frame end
//   odd_sel           parity mode (1 = odd), captured with the first word
//   check_en/bit      parity check enable and expected bit, captured with closing word
//   out_valid/ready   result handshake
//   out_lane_par      bitwise XOR of all words in the frame
//   out_parity        ^out_lane_par ^ odd mode
//   out_count         words in the frame (1..MAX_WORDS)
//   out_err           check_en & (check_bit != out_parity)
//   out_ovf           frame closed at MAX_WORDS without in_last

// One column of the accumulator. The first word of a frame loads the column
// directly instead of XORing, so the block never needs a separate clear cycle.
module xor_parity_lane (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic first,
  input  logic d,
  output logic acc_next,
  output logic acc
);
  assign acc_next = first ? d : (acc ^ d);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    acc <= 1'b0;
    else if (load) acc <= acc_next;
  end
endmodule

module xor_parity_accum #(
  parameter int WIDTH     = 8,
  parameter int MAX_WORDS = 16,
  localparam int CW       = $clog2(MAX_WORDS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  input  logic             odd_sel,
  input  logic             check_en,
  input  logic             check_bit,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_lane_par,
  output logic             out_parity,
  output logic [CW-1:0]    out_count,
  output logic             out_err,
  output logic             out_ovf
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  typedef struct packed {
    logic [WIDTH-1:0] lane;
    logic             parity;
    logic [CW-1:0]    count;
    logic             err;
    logic             ovf;
  } res_t;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_next;
  logic             odd_q, odd_eff;
  logic             accept, first, at_max, closing;
  logic [WIDTH-1:0] acc_next, acc_q;
  res_t             res_q, res_d;

  assign in_ready  = (state_q != HOLD);
  assign out_valid = (state_q == HOLD);
  assign accept    = in_valid & in_ready;
  assign first     = (state_q == IDLE);

  // The counter restarts at 1 on the first word, so it never needs clearing
  // when a frame ends. It cannot pass MAX_WORDS because the frame closes there.
  assign cnt_next = first ? CW'(1) : cnt_q + CW'(1);
  assign at_max   = (cnt_next == CW'(MAX_WORDS));
  assign closing  = in_last | at_max;
  // A one-word frame has no latched mode yet, so take odd_sel straight from the input.
  assign odd_eff  = first ? odd_sel : odd_q;

  for (genvar g = 0; g < WIDTH; g++) begin : g_lane
    xor_parity_lane u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (accept),
      .first    (first),
      .d        (in_data[g]),
      .acc_next (acc_next[g]),
      .acc      (acc_q[g])
    );
  end

  always_comb begin
    res_d        = '0;
    res_d.lane   = acc_next;
    res_d.parity = (^acc_next) ^ odd_eff;
    res_d.count  = cnt_next;
    res_d.err    = check_en & (check_bit != res_d.parity);
    res_d.ovf    = at_max & ~in_last;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, ACCUM: if (accept) state_d = closing ? HOLD : ACCUM;
      HOLD:        if (out_ready) state_d = IDLE;
      default:     state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      odd_q   <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        cnt_q <= cnt_next;
        if (first)   odd_q <= odd_sel;
        // The result stays in res_q after the frame leaves HOLD, until the next frame closes.
        if (closing) res_q <= res_d;
      end
    end
  end

  // acc_q is the running state; the result uses acc_next so the closing word is included.
  logic unused_acc;
  assign unused_acc = ^acc_q;

  assign out_lane_par = res_q.lane;
  assign out_parity   = res_q.parity;
  assign out_count    = res_q.count;
  assign out_err      = res_q.err;
  assign out_ovf      = res_q.ovf;
endmodule

// File: tb/tb_xor_parity_accum.sv
module tb_xor_parity_accum;
  localparam int W    = 8;
  localparam int MAXW = 4;
  localparam int CW   = $clog2(MAXW + 1);

  typedef struct packed {
    logic [W-1:0]  lane;
    logic          parity;
    logic [CW-1:0] count;
    logic          err;
    logic          ovf;
  } res_t;

  logic clk = 0, rst_n = 0;
  logic in_valid = 0, in_last = 0, odd_sel = 0, check_en = 0, check_bit = 0;
  logic [W-1:0] in_data = '0;
  logic out_ready;
  logic in_ready, out_valid, out_parity, out_err, out_ovf;
  logic [W-1:0] out_lane_par;
  logic [CW-1:0] out_count;

  xor_parity_accum #(.WIDTH(W), .MAX_WORDS(MAXW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .odd_sel(odd_sel),
    .check_en(check_en), .check_bit(check_bit), .out_valid(out_valid),
    .out_ready(out_ready), .out_lane_par(out_lane_par), .out_parity(out_parity),
    .out_count(out_count), .out_err(out_err), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  int npass = 0, ntot = 0;
  res_t exp_q[$];
  logic [W-1:0] frame[$];
  logic frame_odd;
  logic bp_rand = 0, ord_force = 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    ntot++;
    if (got === exp) npass++;
    else $display("FAIL %s got=%0h exp=%0h", name, got, exp);
  endtask

  always @(posedge clk) begin
    #1;
    out_ready = bp_rand ? ($urandom_range(0, 3) != 0) : ord_force;
  end

  // Reference model: the result is defined directly from the list of accepted words.
  function automatic res_t model(input logic odd, input logic last, input logic cen, input logic cbit);
    res_t r;
    r.lane = '0;
    foreach (frame[i]) r.lane = r.lane ^ frame[i];
    r.parity = (($countones(r.lane) % 2) == 1) ^ odd;
    r.count  = CW'(frame.size());
    r.err    = cen && (cbit != r.parity);
    r.ovf    = (frame.size() == MAXW) && !last;
    return r;
  endfunction

  task automatic send(input logic [W-1:0] d, input logic last, input logic odd,
                      input logic cen, input logic cbit);
    logic acc;
    int n;
    in_valid = 1; in_data = d; in_last = last; odd_sel = odd; check_en = cen; check_bit = cbit;
    acc = 0; n = 0;
    while (!acc && n < 200) begin
      @(negedge clk); acc = in_ready;
      @(posedge clk); #1; n++;
    end
    in_valid = 0;
    if (!acc) begin chk("accept_timeout", 0, 1); return; end
    if (frame.size() == 0) frame_odd = odd;
    frame.push_back(d);
    if (last || frame.size() == MAXW) begin
      exp_q.push_back(model(frame_odd, last, cen, cbit));
      frame.delete();
    end
  endtask

  // Monitor: pops on each output handshake; also checks outputs hold under backpressure.
  res_t prev;
  logic hold_prev = 0;
  always @(negedge clk) begin
    res_t cur, e;
    cur = '{out_lane_par, out_parity, out_count, out_err, out_ovf};
    if (!rst_n) hold_prev = 0;
    else begin
      if (hold_prev) chk("hold_stable", cur, prev);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_result", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("lane", cur.lane, e.lane);
          chk("parity", cur.parity, e.parity);
          chk("count", cur.count, e.count);
          chk("err", cur.err, e.err);
          chk("ovf", cur.ovf, e.ovf);
        end
      end
      hold_prev = out_valid && !out_ready;
      prev = cur;
    end
  end

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin @(posedge clk); #1; n++; end
    chk("drain", exp_q.size(), 0);
  endtask

  logic sent11;

  initial begin
    #2;
    chk("rst_ready", in_ready, 1);
    chk("rst_valid", out_valid, 0);
    chk("rst_outs", {out_lane_par, out_parity, out_count, out_err, out_ovf}, 0);
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;

    // single word, then latency of one clock to out_valid
    send(8'hA5, 1, 0, 0, 0);
    chk("lat1_valid", out_valid, 1);
    send(8'h01, 0, 1, 0, 0); send(8'h02, 0, 1, 0, 0); send(8'h04, 1, 1, 0, 0);

    // one-bit column sweep: all 3-word patterns, both modes
    for (int p = 0; p < 8; p++)
      for (int o = 0; o < 2; o++) begin
        send({7'd0, p[0]}, 0, o[0], 0, 0);
        send({7'd0, p[1]}, 0, o[0], 0, 0);
        send({7'd0, p[2]}, 1, o[0], 0, 0);
      end
    drain();

    // backpressure
    ord_force = 0;
    @(posedge clk); #1; @(posedge clk); #1;
    send(8'h3C, 1, 0, 0, 0);
    sent11 = 0;
    fork begin send(8'h11, 1, 0, 0, 0); sent11 = 1; end join_none
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
    end
    ord_force = 1;
    @(negedge clk); chk("bp_release_hold", in_ready, 0);
    @(negedge clk); chk("bp_release_ready", in_ready, 1);
    begin
      int n = 0;
      while (!sent11 && n < 50) begin @(posedge clk); #1; n++; end
      chk("bp_sent11", sent11, 1);
    end
    drain();

    // overflow, then a fresh frame
    repeat (4) send(8'hFF, 0, 0, 0, 0);
    send(8'h80, 1, 0, 0, 0);
    // in_last on the MAX_WORDS-th word is not an overflow
    send(8'h01, 0, 0, 0, 0); send(8'h01, 0, 0, 0, 0);
    send(8'h01, 0, 0, 0, 0); send(8'h03, 1, 0, 0, 0);

    // check
    send(8'h03, 1, 0, 1, 1);
    send(8'h03, 1, 0, 1, 0);
    send(8'h03, 1, 0, 0, 1);
    send(8'h01, 1, 0, 1, 0);
    drain();

    // reset mid-frame
    send(8'h12, 0, 0, 0, 0); send(8'h34, 0, 0, 0, 0);
    rst_n = 0; #1;
    chk("midrst_outs", {out_lane_par, out_parity, out_count, out_err, out_ovf}, 0);
    chk("midrst_valid", out_valid, 0);
    frame.delete();
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    send(8'h80, 1, 0, 0, 0);
    drain();

    // randomized frames with random gaps and backpressure
    bp_rand = 1;
    for (int f = 0; f < 40; f++) begin
      int len = $urandom_range(1, MAXW + 1);
      logic o = 1'($urandom_range(0, 1));
      for (int i = 0; i < len && (i == 0 || frame.size() != 0); i++) begin
        send(W'($urandom), (i == len - 1), o, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
    end
    bp_rand = 0; ord_force = 1;
    drain();
    chk("frame_model_empty", frame.size(), 0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
